// File: rtl/fetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_buffer
//
// Instruction prefetch queue between instruction memory and the fetch/decode
// boundary of a 5-stage pipeline. It issues in-order word fetches, buffers up
// to DEPTH returned instructions together with their PC and PC+4, and hands
// them to decode one per cycle under a valid/ready handshake. A taken
// branch/jump redirect from execute flushes the queue and restarts fetching
// at the target. Responses still in flight at the redirect are counted and
// silently discarded when they come back.
//
// The number of buffered entries plus in-flight requests never exceeds DEPTH,
// so a returning response always finds a free slot.
//
// Parameters:
//   DEPTH     queue entries and cap on (buffered + in-flight); power of two, >= 2
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   mem_req_valid/addr fetch request to instruction memory (word aligned)
//   mem_req_ready      memory accepts the request this cycle
//   mem_rsp_valid/data in-order response, latency >= 1 cycle
//   redirect_valid/pc  taken branch/jump from execute (PCSrcE / PCTargetE)
//   instr_valid/ready  handshake toward decode (ready low = stall)
//   instr              head instruction word (InstrD source)
//   instr_pc           head PC (PCD source)
//   instr_pc_plus4     head PC+4 (PCPlus4D source)
//
// Optional feature (compile-time macro PREFETCH_STATS_EN):
//   stat_flush_cnt     entries plus in-flight responses discarded by redirects
//   stat_bubble_cnt    cycles with instr_ready=1 and instr_valid=0
//   Both saturate at 16'hFFFF and clear on rst. Without the macro the ports
//   and counters do not exist.
// -----------------------------------------------------------------------------
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef PREFETCH_STATS_EN
  output logic [15:0] stat_flush_cnt,
  output logic [15:0] stat_bubble_cnt,
`endif
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;   // holds 0..DEPTH
  typedef logic [CNT_W:0]   occ_t;   // holds count + outstanding without overflow

  localparam logic [31:0] START_PC  = {RESET_PC[31:2], 2'b00};
  localparam occ_t        DEPTH_OCC = occ_t'(DEPTH);

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] fetch_pc;     // address of the next request
  logic [31:0] rsp_pc;       // PC that the next kept response belongs to
  cnt_t        count;        // buffered entries
  cnt_t        outstanding;  // requests accepted by memory, response pending
  cnt_t        drop;         // pending responses that belong to a flushed path
  ptr_t        head;
  ptr_t        tail;
  entry_t      entries [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  occ_t        occupancy;
  logic        req_fire;
  logic        rsp_keep;
  logic        push;
  logic        pop;
  cnt_t        outstanding_nxt;
  logic [31:0] redirect_aligned;
  entry_t      head_entry;

  assign occupancy        = occ_t'(count) + occ_t'(outstanding);
  assign mem_req_valid    = !rst && (occupancy < DEPTH_OCC);
  assign mem_req_addr     = fetch_pc;
  assign req_fire         = mem_req_valid && mem_req_ready;

  // A response is kept only when no flushed-path responses remain ahead of it.
  assign rsp_keep         = mem_rsp_valid && (drop == '0);

  // A redirect kills both the same-cycle push and the same-cycle pop.
  assign push             = rsp_keep && !redirect_valid;
  assign pop              = instr_valid && instr_ready && !redirect_valid;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // The two low target bits are ignored: every fetch is word aligned.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // In-flight count after this cycle's request and response. On a redirect
  // this is exactly the number of responses that must be thrown away,
  // including a request accepted in the redirect cycle itself.
  always_comb begin
    // NOTE: assign a default before any conditional update so every path
    // drives the signal and no latch is inferred.
    outstanding_nxt = outstanding;
    if (req_fire) begin
      outstanding_nxt = outstanding_nxt + cnt_t'(1);
    end
    if (mem_rsp_valid) begin
      outstanding_nxt = outstanding_nxt - cnt_t'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      fetch_pc    <= START_PC;
      rsp_pc      <= START_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      outstanding <= outstanding_nxt;

      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        drop     <= outstanding_nxt;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end

        if (mem_rsp_valid && (drop != '0)) begin
          drop <= drop - cnt_t'(1);
        end

        if (push) begin
          tail   <= tail + ptr_t'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end

        if (pop) begin
          head <= head + ptr_t'(1);
        end

        unique case ({push, pop})
          2'b10:   count <= count + cnt_t'(1);
          2'b01:   count <= count - cnt_t'(1);
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read after it has been written, because count gates instr_valid and the
  // outputs below.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{word: mem_rsp_data, pc: rsp_pc, pc_plus4: rsp_pc + 32'd4};
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-side outputs: registered head entry, forced to zero when empty so
  // no stale PC is ever visible.
  // ---------------------------------------------------------------------------
  assign head_entry     = entries[head];
  assign instr_valid    = (count != '0);
  assign instr          = instr_valid ? head_entry.word     : 32'h0;
  assign instr_pc       = instr_valid ? head_entry.pc       : 32'h0;
  assign instr_pc_plus4 = instr_valid ? head_entry.pc_plus4 : 32'h0;

`ifdef PREFETCH_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  // Work thrown away by a redirect: buffered entries, in-flight responses not
  // already marked for dropping, and a request accepted in the same cycle.
  occ_t        flush_amt;
  logic [16:0] flush_sum;

  assign flush_amt = occ_t'(count) + occ_t'(outstanding) - occ_t'(drop)
                   + occ_t'(req_fire);
  assign flush_sum = {1'b0, stat_flush_cnt} + 17'(flush_amt);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_flush_cnt  <= 16'h0;
      stat_bubble_cnt <= 16'h0;
    end else begin
      if (redirect_valid) begin
        stat_flush_cnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
      end
      if (instr_ready && !instr_valid && (stat_bubble_cnt != 16'hFFFF)) begin
        stat_bubble_cnt <= stat_bubble_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_prefetch_buffer
//
// Self-checking bench for fetch_prefetch_buffer (DEPTH=4, RESET_PC=0).
// A small in-order memory model with a configurable fixed latency answers
// every accepted request; the returned word is a fixed function of the
// address so the expected instruction follows from the expected PC.
// Per-cycle vectors cover reset release, steady streaming, stalls with
// throttling, redirects and address wrap; hand-written sequences cover the
// longer-latency redirect cases and the optional statistics counters.
// -----------------------------------------------------------------------------
module tb_fetch_prefetch_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_flush_cnt;
  logic [15:0] stat_bubble_cnt;
`endif

  fetch_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef PREFETCH_STATS_EN
    .stat_flush_cnt (stat_flush_cnt),
    .stat_bubble_cnt(stat_bubble_cnt),
`endif
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Memory model: fixed latency (1..8), in order, cleared by rst.
  // ---------------------------------------------------------------------------
  int          lat = 1;
  logic [7:0]  pipe_v = 8'h0;
  logic [31:0] pipe_a [8];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hC0DE_5A00;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pipe_v <= 8'h0;
    end else begin
      pipe_v   <= {pipe_v[6:0], mem_req_valid && mem_req_ready};
      pipe_a[0] <= mem_req_addr;
      for (int i = 1; i < 8; i++) pipe_a[i] <= pipe_a[i-1];
    end
  end

  assign mem_rsp_valid = pipe_v[lat-1];
  assign mem_rsp_data  = mem_word(pipe_a[lat-1]);

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Check the decode-side outputs against an expected head entry.
  task automatic check_head(input string name, input bit exp_iv, input logic [31:0] exp_pc);
    check({name, "_iv"},  {31'h0, instr_valid}, {31'h0, exp_iv});
    check({name, "_pc"},  instr_pc,             exp_iv ? exp_pc : 32'h0);
    check({name, "_pc4"}, instr_pc_plus4,       exp_iv ? exp_pc + 32'd4 : 32'h0);
    check({name, "_ins"}, instr,                exp_iv ? mem_word(exp_pc) : 32'h0);
  endtask

  // Reset for two edges; returns #1 after the last reset edge with rst low.
  task automatic do_reset(input int latency);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    mem_req_ready  = 1'b1;
    lat            = latency;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Wait (bounded) at negedges until instr_valid; returns cycles waited.
  task automatic wait_valid(output int waited);
    waited = 0;
    while (!instr_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle vectors (memory latency 1, mem_req_ready=1)
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          do_reset;
    bit          ready;
    bit          redir;
    logic [31:0] redir_pc;
    bit          exp_req_valid;
    logic [31:0] exp_req_addr;
    bit          exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit rs, input bit rd, input bit rv_in,
                              input logic [31:0] rpc, input bit erv,
                              input logic [31:0] eaddr, input bit eiv,
                              input logic [31:0] epc);
    vec_t v;
    v.do_reset      = rs;
    v.ready         = rd;
    v.redir         = rv_in;
    v.redir_pc      = rpc;
    v.exp_req_valid = erv;
    v.exp_req_addr  = eaddr;
    v.exp_iv        = eiv;
    v.exp_pc        = epc;
    return v;
  endfunction

  initial begin
    int waited;

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    mem_req_ready  = 1'b1;

    // Streaming from reset, redirect with same-cycle response+pop, wrap.
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0000));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_000C, 1, 32'h0000_0004));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_0010, 1, 32'h0000_0008));
    vecs.push_back(mk(0, 1, 1, 32'h0000_0202, 1, 32'h0000_0014, 1, 32'h0000_000C));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_0200, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_0204, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_0208, 1, 32'h0000_0200));
    vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFF9, 1, 32'h0000_020C, 1, 32'h0000_0204));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'hFFFF_FFF8, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_0000, 1, 32'hFFFF_FFF8));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_0004, 1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0000));
    // Mid-operation reset, then decode stalled for 10 cycles: 4 requests only.
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0000));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h0000_000C, 1, 32'h0000_0000));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 0, 0, 32'h0,       0, 32'h0000_0010, 1, 32'h0000_0000));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0000_0010, 1, 32'h0000_0000));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_0010, 1, 32'h0000_0004));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_0014, 1, 32'h0000_0008));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_0018, 1, 32'h0000_000C));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0000_001C, 1, 32'h0000_0010));

    // --- Reset state -------------------------------------------------------
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check("rst_req_addr",  mem_req_addr,           RESET_PC);
    check_head("rst", 1'b0, 32'h0);
`ifdef PREFETCH_STATS_EN
    check("rst_flush_cnt",  {16'h0, stat_flush_cnt},  32'h0);
    check("rst_bubble_cnt", {16'h0, stat_bubble_cnt}, 32'h0);
`endif

    // --- Vector table ------------------------------------------------------
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_reset) do_reset(1);
      instr_ready    = vecs[i].ready;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].redir_pc;
      @(negedge clk);
      check($sformatf("v%0d_req_valid", i), {31'h0, mem_req_valid},
            {31'h0, vecs[i].exp_req_valid});
      check($sformatf("v%0d_req_addr", i), mem_req_addr, vecs[i].exp_req_addr);
      check_head($sformatf("v%0d", i), vecs[i].exp_iv, vecs[i].exp_pc);
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;

    // --- Latency 3: redirect to 0x103 with two requests in flight ----------
    do_reset(3);
    instr_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    @(negedge clk);
    check("l3_req_valid", {31'h0, mem_req_valid}, 32'h1);
    check("l3_req_addr",  mem_req_addr,           32'h0000_0100);
    check("l3_iv_after",  {31'h0, instr_valid},   32'h0);
    wait_valid(waited);
    check("l3_wait", waited, 4);
    check_head("l3_first", 1'b1, 32'h0000_0100);

    // --- Latency 3: back-to-back redirects, drop must accumulate -----------
    do_reset(3);
    instr_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    @(posedge clk); #1;
    redirect_pc    = 32'h0000_0400;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("b2b_req_addr", mem_req_addr, 32'h0000_0400);
    wait_valid(waited);
    check("b2b_wait", waited, 4);
    check_head("b2b_first", 1'b1, 32'h0000_0400);
    @(negedge clk);
    check_head("b2b_second", 1'b1, 32'h0000_0404);

`ifdef PREFETCH_STATS_EN
    // --- Statistics: 3 queued + 1 in flight flushed, then 5 bubbles --------
    do_reset(1);
    instr_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0500;
    @(negedge clk);
    check("st_full_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check("st_full_iv",        {31'h0, instr_valid},   32'h1);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b0;
    instr_ready    = 1'b1;
    @(negedge clk);
    check("st_flush_cnt",    {16'h0, stat_flush_cnt},  32'd4);
    check("st_bubble_start", {16'h0, stat_bubble_cnt}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    instr_ready = 1'b0;
    @(negedge clk);
    check("st_bubble_cnt",   {16'h0, stat_bubble_cnt}, 32'd5);
    check("st_flush_hold",   {16'h0, stat_flush_cnt},  32'd4);
    mem_req_ready = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
